pdecoder_pipe: RTL and testbench

PDECODER_PIPE -- requirements
Module: pdecoder_pipe

---
 rtl/pdecoder_pipe.sv | 106 ++++++++++
 tb/tb_pdecoder_pipe.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pdecoder_pipe.sv
// 2-to-4 decoder feeding a 2-entry valid/ready FIFO of decoded one-hot words.
// Define PDECODER_CNT_EN to add the 8-bit delivered-item counter output cnt.
module pdecoder_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] code,
  input  logic       code_ok,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out,
  output logic       out_valid,
  input  logic       out_ready
`ifdef PDECODER_CNT_EN
  ,
  output logic [7:0] cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} StateT;

  StateT      r_state;
  StateT      w_stateNext;
  logic [3:0] r_head;
  logic [3:0] r_tail;
  logic [3:0] w_dec;
  logic       w_push;
  logic       w_pop;
  logic       w_loadHead;
  logic       w_loadTail;
  logic       w_shift;
  logic       w_clearHead;

  assign w_dec     = code_ok ? (4'b0001 << code) : 4'b0000;
  assign in_ready  = ~rst & (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign out       = out_valid ? r_head : 4'b0000;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_stateNext;
  end

  // Head always holds the oldest item; a simultaneous push/pop in ONE replaces it.
  always_comb begin
    w_stateNext = r_state;
    w_loadHead  = 1'b0;
    w_loadTail  = 1'b0;
    w_shift     = 1'b0;
    w_clearHead = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_stateNext = ONE;
          w_loadHead  = 1'b1;
        end
      end
      ONE: begin
        if (w_push && w_pop) begin
          w_loadHead = 1'b1;
        end else if (w_push) begin
          w_stateNext = FULL;
          w_loadTail  = 1'b1;
        end else if (w_pop) begin
          w_stateNext = EMPTY;
          w_clearHead = 1'b1;
        end
      end
      FULL: begin
        if (w_pop) begin
          w_stateNext = ONE;
          w_shift     = 1'b1;
        end
      end
      default: w_stateNext = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= 4'b0000;
      r_tail <= 4'b0000;
    end else begin
      if (w_loadHead)  r_head <= w_dec;
      if (w_clearHead) r_head <= 4'b0000;
      if (w_loadTail)  r_tail <= w_dec;
      if (w_shift) begin
        r_head <= r_tail;
        r_tail <= 4'b0000;
      end
    end
  end

`ifdef PDECODER_CNT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)        r_cnt <= 8'd0;
    else if (w_pop) r_cnt <= r_cnt + 8'd1;
  end

  assign cnt = r_cnt;
`endif

endmodule

// File: tb/tb_pdecoder_pipe.sv
// Self-checking bench for pdecoder_pipe; a queue scoreboard models the FIFO.
// Compile with PDECODER_CNT_EN defined to also check the cnt output.
module tb_pdecoder_pipe;

  logic       clk;
  logic       rst;
  logic [1:0] code;
  logic       code_ok;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out;
  logic       out_valid;
  logic       out_ready;
`ifdef PDECODER_CNT_EN
  logic [7:0] cnt;
`endif

  int         checks;
  int         errors;
  logic [3:0] sbQueue[$];
  logic [7:0] cntModel;

  pdecoder_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .code      (code),
    .code_ok   (code_ok),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PDECODER_CNT_EN
    ,
    .cnt       (cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after negedge, check outputs against the model, update model at posedge.
  task automatic applyStimulus(input logic r, input logic iv, input logic [1:0] c, input logic ok,
                               input logic ordy);
    logic       expReady;
    logic       expValid;
    logic [3:0] expOut;
    logic [3:0] expDec;
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    code      = c;
    code_ok   = ok;
    out_ready = ordy;
    #2;
    expReady = !r && (sbQueue.size() < 2);
    expValid = (sbQueue.size() > 0);
    expOut   = expValid ? sbQueue[0] : 4'b0000;
    expDec   = ok ? (4'b0001 << c) : 4'b0000;
    checkOutput("in_ready", {7'd0, in_ready}, {7'd0, expReady});
    checkOutput("out_valid", {7'd0, out_valid}, {7'd0, expValid});
    checkOutput("out", {4'd0, out}, {4'd0, expOut});
`ifdef PDECODER_CNT_EN
    checkOutput("cnt", cnt, cntModel);
`endif
    if (r) begin
      sbQueue.delete();
      cntModel = 8'd0;
    end else begin
      if (expValid && ordy) begin
        void'(sbQueue.pop_front());
        cntModel = cntModel + 8'd1;
      end
      if (iv && expReady) sbQueue.push_back(expDec);
    end
    @(posedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cntModel  = 8'd0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    code      = 2'b00;
    code_ok   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held: FIFO empty, in_ready forced low
    applyStimulus(1, 1, 2'b01, 1, 1);
    applyStimulus(0, 0, 2'b00, 0, 1);

    // Single item
    applyStimulus(0, 1, 2'b10, 1, 1);
    applyStimulus(0, 0, 2'b00, 0, 1);
    applyStimulus(0, 0, 2'b00, 0, 1);

    // Invalid code delivered as zero word
    applyStimulus(0, 1, 2'b11, 0, 1);
    applyStimulus(0, 0, 2'b00, 0, 1);

    // Fill and stall, then drain
    applyStimulus(0, 1, 2'b00, 1, 0);
    applyStimulus(0, 1, 2'b01, 1, 0);
    applyStimulus(0, 1, 2'b10, 1, 0);
    applyStimulus(0, 1, 2'b11, 1, 0);
    applyStimulus(0, 0, 2'b00, 0, 1);
    applyStimulus(0, 0, 2'b00, 0, 1);
    applyStimulus(0, 0, 2'b00, 0, 1);

    // Streaming four codes back to back
    applyStimulus(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, i[1:0], 1, 1);
    applyStimulus(0, 0, 2'b00, 0, 1);
`ifdef PDECODER_CNT_EN
    checkOutput("cntStream4", cnt, 8'd4);
`endif

    // Reset while FULL discards buffered items
    applyStimulus(0, 1, 2'b10, 1, 0);
    applyStimulus(0, 1, 2'b11, 1, 0);
    applyStimulus(1, 1, 2'b00, 1, 1);
    applyStimulus(0, 0, 2'b00, 0, 1);
    applyStimulus(0, 1, 2'b01, 1, 1);
    applyStimulus(0, 0, 2'b00, 0, 1);
    applyStimulus(0, 0, 2'b00, 0, 1);

    // Random handshakes with backpressure
    for (int i = 0; i < 80; i++)
      applyStimulus(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2'b00, 0, 1);

    // Deliver 256 items from reset; counter wraps to zero
    applyStimulus(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 256; i++)
      applyStimulus(0, 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1);
    applyStimulus(0, 0, 2'b00, 0, 1);
    applyStimulus(0, 0, 2'b00, 0, 1);
`ifdef PDECODER_CNT_EN
    checkOutput("cntWrap", cnt, 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
